// File: rtl/simon_sequencer.sv
// Round controller for the memory game: grows a random pattern, plays it on one-hot LEDs, checks presses.
// Latency: rand_in captured the cycle after start; button presses take effect at the sampling edge.
// No backpressure: start/btn_valid are single-cycle pulses, discarded in states that do not use them.
module simon_sequencer #(
    parameter int MAX_LEN    = 32,
    parameter int ON_CYCLES  = 12_000_000,
    parameter int OFF_CYCLES = 6_000_000
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [1:0]                   rand_in,
    input  logic                         start,
    input  logic                         btn_valid,
    input  logic [1:0]                   btn_id,
    output logic [3:0]                   led,
    output logic                         awaiting_input,
    output logic [$clog2(MAX_LEN+1)-1:0] score,
    output logic                         game_over,
    output logic                         win
);

    localparam int LEN_W   = $clog2(MAX_LEN + 1);
    localparam int IDX_W   = $clog2(MAX_LEN);
    localparam int TMR_MAX = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [TMR_W-1:0] ON_LAST  = TMR_W'(ON_CYCLES - 1);
    localparam logic [TMR_W-1:0] OFF_LAST = TMR_W'(OFF_CYCLES - 1);
    localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_LEN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_APPEND,
        S_SHOW_ON,
        S_SHOW_OFF,
        S_WAIT_INPUT,
        S_LOSE,
        S_WIN
    } state_t;

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   length_q, length_d;
    logic [LEN_W-1:0]   index_q, index_d;
    logic [LEN_W-1:0]   score_q, score_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [1:0]         mem_q [MAX_LEN];
    logic               mem_we;
    logic [1:0]         cur_val;
    logic               last_step;

    // Pattern entry under the playback/check pointer, and whether it is the final entry.
    assign cur_val   = mem_q[index_q[IDX_W-1:0]];
    assign last_step = (index_q == (length_q - LEN_W'(1)));

    // Control registers; asynchronous reset returns the game to IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            length_q <= '0;
            index_q  <= '0;
            score_q  <= '0;
            timer_q  <= '0;
        end else begin
            state_q  <= state_d;
            length_q <= length_d;
            index_q  <= index_d;
            score_q  <= score_d;
            timer_q  <= timer_d;
        end
    end

    // Pattern buffer: written once per round in APPEND; contents need no reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[length_q[IDX_W-1:0]] <= rand_in;
        end
    end

    // Next-state logic: round growth, timed playback, and press checking.
    always_comb begin
        state_d  = state_q;
        length_d = length_q;
        index_d  = index_q;
        score_d  = score_q;
        timer_d  = timer_q;
        mem_we   = 1'b0;
        case (state_q)
            S_IDLE, S_LOSE, S_WIN: begin
                if (start) begin
                    length_d = '0;
                    index_d  = '0;
                    score_d  = '0;
                    state_d  = S_APPEND;
                end
            end
            S_APPEND: begin
                mem_we   = 1'b1;
                length_d = length_q + LEN_W'(1);
                index_d  = '0;
                timer_d  = '0;
                state_d  = S_SHOW_ON;
            end
            S_SHOW_ON: begin
                if (timer_q == ON_LAST) begin
                    timer_d = '0;
                    state_d = S_SHOW_OFF;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            S_SHOW_OFF: begin
                if (timer_q == OFF_LAST) begin
                    timer_d = '0;
                    if (last_step) begin
                        index_d = '0;
                        state_d = S_WAIT_INPUT;
                    end else begin
                        index_d = index_q + LEN_W'(1);
                        state_d = S_SHOW_ON;
                    end
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            S_WAIT_INPUT: begin
                if (btn_valid) begin
                    if (btn_id != cur_val) begin
                        state_d = S_LOSE;
                    end else if (last_step) begin
                        score_d = length_q;
                        state_d = (length_q == LEN_MAX) ? S_WIN : S_APPEND;
                    end else begin
                        index_d = index_q + LEN_W'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Moore output decode from registered state.
    always_comb begin
        led            = 4'b0000;
        awaiting_input = (state_q == S_WAIT_INPUT);
        game_over      = (state_q == S_LOSE);
        win            = (state_q == S_WIN);
        if (state_q == S_SHOW_ON) begin
            led = 4'b0001 << cur_val;
        end
    end

    assign score = score_q;

endmodule

// File: tb/tb_simon_sequencer.sv
module tb_simon_sequencer;

    localparam int MAX_LEN = 4;
    localparam int SW      = $clog2(MAX_LEN + 1);

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    rand_in;
    logic          start;
    logic          btn_valid;
    logic [1:0]    btn_id;
    logic [3:0]    led;
    logic          awaiting_input;
    logic [SW-1:0] score;
    logic          game_over;
    logic          win;

    int vectors = 0;
    int misses  = 0;

    logic [1:0] pat [4];

    simon_sequencer #(
        .MAX_LEN   (MAX_LEN),
        .ON_CYCLES (4),
        .OFF_CYCLES(2)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .rand_in       (rand_in),
        .start         (start),
        .btn_valid     (btn_valid),
        .btn_id        (btn_id),
        .led           (led),
        .awaiting_input(awaiting_input),
        .score         (score),
        .game_over     (game_over),
        .win           (win)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_led(input string tag, input logic [3:0] exp);
        vectors++;
        assert (led === exp) else begin
            misses++;
            $error("FAIL %s: led observed %b expected %b", tag, led, exp);
        end
    endtask

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            misses++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_score(input string tag, input logic [SW-1:0] exp);
        vectors++;
        assert (score === exp) else begin
            misses++;
            $error("FAIL %s: score observed %0d expected %0d", tag, score, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk_led(tag, 4'b0000);
        chk_bit({tag, "_await"}, awaiting_input, 1'b0);
        chk_score(tag, '0);
        chk_bit({tag, "_over"}, game_over, 1'b0);
        chk_bit({tag, "_win"}, win, 1'b0);
    endtask

    // One playback step: 4 lit cycles then 2 dark cycles, leaves bench at next step's first cycle.
    task automatic play_step(input string tag, input logic [3:0] exp);
        for (int i = 0; i < 4; i++) begin
            chk_led({tag, "_on"}, exp);
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            chk_led({tag, "_off"}, 4'b0000);
            chk_bit({tag, "_off_await"}, awaiting_input, 1'b0);
            tick();
        end
    endtask

    initial begin
        reset     = 1'b1;
        rand_in   = 2'd0;
        start     = 1'b0;
        btn_valid = 1'b0;
        btn_id    = 2'd0;

        // 1. reset values, held with no start
        #1;
        chk_idle_outputs("rst_async");
        tick();
        tick();
        reset = 1'b0;
        tick();
        tick();
        tick();
        chk_idle_outputs("rst_hold");

        // 2. first round with rand_in=2
        start   = 1'b1;
        rand_in = 2'd2;
        tick();
        start = 1'b0;
        chk_led("append1", 4'b0000);
        tick();
        play_step("r1_s0", 4'b0100);
        chk_bit("r1_await", awaiting_input, 1'b1);
        chk_led("r1_await_led", 4'b0000);

        // 3. correct press, second round appends 0
        btn_valid = 1'b1;
        btn_id    = 2'd2;
        rand_in   = 2'd0;
        tick();
        btn_valid = 1'b0;
        chk_score("r2_score", SW'(1));
        chk_bit("r2_append_await", awaiting_input, 1'b0);
        chk_led("r2_append_led", 4'b0000);
        tick();
        play_step("r2_s0", 4'b0100);
        play_step("r2_s1", 4'b0001);
        chk_bit("r2_await", awaiting_input, 1'b1);

        // 4. correct first press, wrong second press (expects 0, give 3)
        btn_valid = 1'b1;
        btn_id    = 2'd2;
        tick();
        chk_bit("r3_mid_await", awaiting_input, 1'b1);
        btn_id = 2'd3;
        tick();
        btn_valid = 1'b0;
        chk_bit("lose_over", game_over, 1'b1);
        chk_bit("lose_await", awaiting_input, 1'b0);
        chk_score("lose_score", SW'(1));
        tick();
        chk_bit("lose_hold", game_over, 1'b1);

        // restart from LOSE with pattern 1,3,0,2
        pat[0] = 2'd1;
        pat[1] = 2'd3;
        pat[2] = 2'd0;
        pat[3] = 2'd2;
        start   = 1'b1;
        rand_in = pat[0];
        tick();
        start = 1'b0;
        chk_bit("restart_over", game_over, 1'b0);
        chk_score("restart_score", '0);
        tick();
        play_step("g2_r1", 4'b0010);
        chk_bit("g2_r1_await", awaiting_input, 1'b1);

        // 5. answer all four rounds
        for (int r = 1; r <= 4; r++) begin
            for (int i = 0; i < r; i++) begin
                btn_valid = 1'b1;
                btn_id    = pat[i];
                if (r < 4) rand_in = pat[r];
                tick();
                btn_valid = 1'b0;
            end
            chk_score("round_score", SW'(r));
            if (r < 4) begin
                tick();
                for (int i = 0; i <= r; i++) begin
                    play_step("win_play", 4'b0001 << pat[i]);
                end
                chk_bit("win_play_await", awaiting_input, 1'b1);
            end
        end
        chk_bit("win_flag", win, 1'b1);
        chk_bit("win_await", awaiting_input, 1'b0);
        btn_valid = 1'b1;
        btn_id    = 2'd0;
        tick();
        btn_valid = 1'b0;
        tick();
        chk_bit("win_hold", win, 1'b1);
        chk_score("win_hold_score", SW'(4));

        // 6. start/btn during SHOW_ON ignored, then mid-SHOW_ON reset
        start   = 1'b1;
        rand_in = 2'd3;
        tick();
        start = 1'b0;
        chk_bit("g3_win_clr", win, 1'b0);
        chk_score("g3_score", '0);
        tick();
        chk_led("g3_on1", 4'b1000);
        tick();
        chk_led("g3_on2", 4'b1000);
        btn_valid = 1'b1;
        btn_id    = 2'd2;
        start     = 1'b1;
        tick();
        btn_valid = 1'b0;
        start     = 1'b0;
        chk_led("g3_on3", 4'b1000);
        chk_bit("g3_on3_over", game_over, 1'b0);
        tick();
        chk_led("g3_on4", 4'b1000);
        tick();
        chk_led("g3_off1", 4'b0000);
        tick();
        chk_led("g3_off2", 4'b0000);
        tick();
        chk_bit("g3_await", awaiting_input, 1'b1);
        btn_valid = 1'b1;
        btn_id    = 2'd3;
        rand_in   = 2'd1;
        tick();
        btn_valid = 1'b0;
        chk_score("g3_r1_score", SW'(1));
        tick();
        chk_led("g3_r2_on", 4'b1000);
        #2;
        reset = 1'b1;
        #1;
        chk_idle_outputs("rst_mid");
        tick();
        reset = 1'b0;
        tick();
        tick();
        chk_idle_outputs("rst_mid_idle");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
        $finish;
    end

endmodule
